segment_deserializer: RTL

SEGMENT_DESERIALIZER -- requirements
Module: segment_deserializer

---
 rtl/segment_deserializer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/segment_deserializer.sv
// Collects num_segments narrow segments into one wide word with first-segment
// realignment, single-entry output register and saturating drop counter.
//
// state    | meaning
// HUNT     | waiting for a segment flagged in_first; others are dropped
// ASSEMBLE | collecting segments 1..num_segments-1 of the current word
module segment_deserializer #(
  parameter int bit_width     = 512,
  parameter int segment_width = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [segment_width-1:0] in_data,
  input  logic                     in_first,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [bit_width-1:0]     out_data,
  output logic                     out_err,
  output logic [15:0]              drop_count
);

  localparam int num_segments = bit_width / segment_width;
  localparam int cnt_w        = $clog2(num_segments);
  localparam logic [cnt_w-1:0] last_seg = cnt_w'(num_segments - 1);

  generate
    if ((num_segments * segment_width != bit_width) || (num_segments < 2)) begin : g_bad_params
      $error("segment_deserializer: bit_width must be an exact multiple (>=2) of segment_width");
    end
  endgenerate

  typedef enum logic {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [cnt_w-1:0]       seg_cnt_q, seg_cnt_d;
  logic                   pend_err_q, pend_err_d;
  logic [bit_width-1:0]   asm_q, asm_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_err_q, out_err_d;
  logic [bit_width-1:0]   out_data_q, out_data_d;
  logic [15:0]            drop_q, drop_d;

  logic                   accept;
  logic                   xfer;
  logic [cnt_w-1:0]       wr_idx;
  logic [16:0]            drop_inc;
  logic [16:0]            drop_sum;

  // Only the final segment can stall, and only while the output slot is full
  // and not draining; reset forces ready so in-reset traffic is simply swallowed.
  assign in_ready = !reset ||
                    !((state_q == ASSEMBLE) && (seg_cnt_q == last_seg) &&
                      out_valid_q && !out_ready);

  assign accept = in_valid && in_ready;
  assign xfer   = out_valid_q && out_ready;
  assign wr_idx = in_first ? '0 : seg_cnt_q;

  always_comb begin
    state_d     = state_q;
    seg_cnt_d   = seg_cnt_q;
    pend_err_d  = pend_err_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_data_d  = out_data_q;
    drop_inc    = '0;

    if (xfer) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      for (int k = 0; k < num_segments; k++) begin
        if (wr_idx == cnt_w'(k)) begin
          asm_d[k*segment_width +: segment_width] = in_data;
        end
      end

      case (state_q)
        HUNT: begin
          if (in_first) begin
            seg_cnt_d = cnt_w'(1);
            state_d   = ASSEMBLE;
          end else begin
            drop_inc = 17'd1;
          end
        end
        ASSEMBLE: begin
          if (in_first) begin
            drop_inc   = 17'(seg_cnt_q);
            seg_cnt_d  = cnt_w'(1);
            pend_err_d = 1'b1;
          end else if (seg_cnt_q == last_seg) begin
            out_data_d  = asm_d;
            out_err_d   = pend_err_q;
            out_valid_d = 1'b1;
            pend_err_d  = 1'b0;
            seg_cnt_d   = '0;
            state_d     = HUNT;
          end else begin
            seg_cnt_d = seg_cnt_q + cnt_w'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    drop_sum = {1'b0, drop_q} + drop_inc;
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= HUNT;
      seg_cnt_q   <= '0;
      pend_err_q  <= 1'b0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      seg_cnt_q   <= seg_cnt_d;
      pend_err_q  <= pend_err_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_err    = out_err_q;
  assign out_data   = out_data_q;
  assign drop_count = drop_q;

endmodule
